// File: rtl/register_load_arbiter_pkg.sv
// Shared types and sizing helpers for the register load arbiter.
package register_load_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Index width for a requester count; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned IDX_W     = idx_w(N_REQ_DEF);

endpackage

// File: rtl/register_load_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible request at or after ptr, wrapping.
module rr_pick
  import register_load_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner_c,
  output logic             valid_c
);

  localparam int unsigned SW = IW + 1;

  logic [N_REQ-1:0] eligible;
  logic [SW-1:0]    idx;

  always_comb begin
    eligible = req & ~mask;
    winner_c = '0;
    valid_c  = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + SW'(k);
      if (idx >= SW'(N_REQ)) idx = idx - SW'(N_REQ);
      if (!valid_c && eligible[idx[IW-1:0]]) begin
        valid_c  = 1'b1;
        winner_c = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/register_load_arbiter.sv
// Round-robin arbiter feeding one shared negedge-loading register (active-low enable).
module register_load_arbiter
  import register_load_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IW    = idx_w(N_REQ)
) (
  input  logic                   Clk,
  input  logic                   Resetbar,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*WIDTH-1:0] Data,
  output logic [N_REQ-1:0]       Grant,
  output logic [N_REQ-1:0]       Ack,
  output logic [WIDTH-1:0]       RegIn,
  output logic                   RegEnbar,
  output logic                   Busy,
  output logic [IW-1:0]          LastOwner
);

  state_e           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    winner, winner_n;
  logic [IW-1:0]    last_owner_n;
  logic [WIDTH-1:0] hold_n;
  logic [N_REQ-1:0] grant_n, ack_n, mask;
  logic             regenbar_n, busy_n;
  logic [IW-1:0]    pick_c;
  logic             pick_valid_c;
  logic [WIDTH-1:0] data_arr [N_REQ];

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = Data[i*WIDTH +: WIDTH];
  end

  // The requester just acknowledged may not win again straight out of ACK.
  assign mask = (state == ACK) ? onehot(winner) : '0;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (Req),
    .mask     (mask),
    .ptr      (ptr),
    .winner_c (pick_c),
    .valid_c  (pick_valid_c)
  );

  always_ff @(posedge Clk or negedge Resetbar) begin
    if (!Resetbar) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    winner_n     = winner;
    last_owner_n = LastOwner;
    hold_n       = RegIn;
    grant_n      = '0;
    ack_n        = '0;
    regenbar_n   = 1'b1;
    busy_n       = 1'b0;
    case (state)
      IDLE, ACK: begin
        if (pick_valid_c) begin
          state_n    = LOAD;
          winner_n   = pick_c;
          hold_n     = data_arr[pick_c];
          grant_n    = onehot(pick_c);
          regenbar_n = 1'b0;
          busy_n     = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        state_n      = ACK;
        ack_n        = onehot(winner);
        busy_n       = 1'b1;
        last_owner_n = winner;
        ptr_n        = (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // Output and bookkeeping registers; RegEnbar returns high at once on reset.
  always_ff @(posedge Clk or negedge Resetbar) begin
    if (!Resetbar) begin
      ptr       <= '0;
      winner    <= '0;
      LastOwner <= '0;
      RegIn     <= '0;
      Grant     <= '0;
      Ack       <= '0;
      RegEnbar  <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      winner    <= winner_n;
      LastOwner <= last_owner_n;
      RegIn     <= hold_n;
      Grant     <= grant_n;
      Ack       <= ack_n;
      RegEnbar  <= regenbar_n;
      Busy      <= busy_n;
    end
  end

endmodule
